ula_multiciclo: RTL and testbench

ULA_MULTICICLO -- requirements
Module: ula_multiciclo

---
 rtl/ula_multiciclo.sv | 166 ++++++++++++++++
 tb/tb_ula_multiciclo.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: ALU with single-cycle add/subtract and iterative unsigned
// multiply (shift-and-add) and divide (restoring), one bit per clock.
// Compare flags are purely combinational on the live operands.
module ula_multiciclo #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] dina,
    input  logic [BITS-1:0] dinb,
    input  logic [BITS-1:0] imm,
    input  logic            usa_imm,
    input  logic [2:0]      op,
    input  logic            start,
    output logic [BITS-1:0] dout,
    output logic            pronto,
    output logic            ocupado,
    output logic            flag_igual,
    output logic            flag_menor,
    output logic            flag_maior_igual_u
);

    localparam int CW = $clog2(BITS);

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        FIM
    } estado_t;

    typedef enum logic [2:0] {
        OP_NAO     = 3'd0,
        OP_SOMA    = 3'd1,
        OP_SUBTRAI = 3'd2,
        OP_MUL     = 3'd3,
        OP_MULHU   = 3'd4,
        OP_DIVU    = 3'd5,
        OP_REMU    = 3'd6,
        OP_RESERV  = 3'd7
    } op_t;

    estado_t           r_estado;
    op_t               r_op;
    logic [BITS-1:0]   r_a;       // latched multiplicand
    logic [BITS-1:0]   r_b;       // latched divisor
    logic [2*BITS-1:0] r_prod;    // {partial sum, remaining multiplier bits}
    logic [BITS-1:0]   r_quoc;    // dividend shifts out, quotient shifts in
    logic [BITS-1:0]   r_resto;
    logic [CW-1:0]     r_cont;

    logic [BITS-1:0]   w_fator2;
    logic [BITS:0]     w_mul_soma;
    logic [BITS:0]     w_div_parcial;
    logic [BITS:0]     w_div_dif;
    logic              w_div_cabe;

    assign w_fator2 = usa_imm ? imm : dinb;

    // One multiply step: add the multiplicand when the current multiplier bit is set.
    assign w_mul_soma = {1'b0, r_prod[2*BITS-1:BITS]} + (r_prod[0] ? {1'b0, r_a} : '0);

    // One restoring-divide step: bring in the next dividend bit and trial-subtract.
    assign w_div_parcial = {r_resto, r_quoc[BITS-1]};
    assign w_div_dif     = w_div_parcial - {1'b0, r_b};
    assign w_div_cabe    = ~w_div_dif[BITS];

    // Compare flags follow the live inputs regardless of FSM state or usa_imm.
    assign flag_igual         = (dina == dinb);
    assign flag_menor         = ($signed(dina) < $signed(dinb));
    assign flag_maior_igual_u = (dina >= dinb);

    // Control FSM and datapath registers with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath registers are reset too so an aborted operation leaves no residue.
            r_estado <= OCIOSO;
            r_op     <= OP_NAO;
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            r_quoc   <= '0;
            r_resto  <= '0;
            r_cont   <= '0;
            dout     <= '0;
            pronto   <= 1'b0;
            ocupado  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (start) begin
                        r_op <= op_t'(op);
                        r_a  <= dina;
                        r_b  <= w_fator2;
                        case (op_t'(op))
                            OP_SOMA: begin
                                dout   <= dina + w_fator2;
                                pronto <= 1'b1;
                            end
                            OP_SUBTRAI: begin
                                dout   <= dina - w_fator2;
                                pronto <= 1'b1;
                            end
                            OP_MUL, OP_MULHU: begin
                                r_prod   <= {{BITS{1'b0}}, w_fator2};
                                r_cont   <= CW'(BITS - 1);
                                ocupado  <= 1'b1;
                                r_estado <= CALCULA;
                            end
                            OP_DIVU, OP_REMU: begin
                                if (w_fator2 == '0) begin
                                    // Division by zero short-circuits without iterating.
                                    dout   <= (op_t'(op) == OP_DIVU) ? '1 : dina;
                                    pronto <= 1'b1;
                                end else begin
                                    r_quoc   <= dina;
                                    r_resto  <= '0;
                                    r_cont   <= CW'(BITS - 1);
                                    ocupado  <= 1'b1;
                                    r_estado <= CALCULA;
                                end
                            end
                            default: begin
                                dout   <= '0;
                                pronto <= 1'b1;
                            end
                        endcase
                    end
                end

                CALCULA: begin
                    if (r_op == OP_MUL || r_op == OP_MULHU) begin
                        r_prod <= {w_mul_soma, r_prod[BITS-1:1]};
                    end else begin
                        r_resto <= w_div_cabe ? w_div_dif[BITS-1:0] : w_div_parcial[BITS-1:0];
                        r_quoc  <= {r_quoc[BITS-2:0], w_div_cabe};
                    end
                    if (r_cont == '0) begin
                        r_estado <= FIM;
                    end else begin
                        r_cont <= r_cont - CW'(1);
                    end
                end

                FIM: begin
                    case (r_op)
                        OP_MUL:   dout <= r_prod[BITS-1:0];
                        OP_MULHU: dout <= r_prod[2*BITS-1:BITS];
                        OP_DIVU:  dout <= r_quoc;
                        default:  dout <= r_resto;
                    endcase
                    pronto   <= 1'b1;
                    ocupado  <= 1'b0;
                    r_estado <= OCIOSO;
                end

                default: begin
                    ocupado  <= 1'b0;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: scoreboard bench for ula_multiciclo (BITS=64).
// Expected results and their pronto cycle are queued when start is driven;
// a negedge monitor pops and compares them whenever pronto is seen.
module tb_ula_multiciclo;

    localparam int BITS     = 64;
    localparam int LAT_ITER = BITS + 1;

    typedef struct {
        logic [BITS-1:0] dout;
        int              cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [BITS-1:0] dina;
    logic [BITS-1:0] dinb;
    logic [BITS-1:0] imm;
    logic            usa_imm;
    logic [2:0]      op;
    logic            start;
    logic [BITS-1:0] dout;
    logic            pronto;
    logic            ocupado;
    logic            flag_igual;
    logic            flag_menor;
    logic            flag_maior_igual_u;

    exp_t            sb_q[$];
    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;      // number of rising edges so far
    logic            rst_at_edge;
    logic [BITS-1:0] hold_val = '0;

    ula_multiciclo #(.BITS(BITS)) dut (
        .clk                (clk),
        .reset              (reset),
        .dina               (dina),
        .dinb               (dinb),
        .imm                (imm),
        .usa_imm            (usa_imm),
        .op                 (op),
        .start              (start),
        .dout               (dout),
        .pronto             (pronto),
        .ocupado            (ocupado),
        .flag_igual         (flag_igual),
        .flag_menor         (flag_menor),
        .flag_maior_igual_u (flag_maior_igual_u)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    // Scoreboard monitor: every pronto must match the queue head in value and
    // cycle; between pulses dout must hold the last result (0 after reset).
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (pronto === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pronto: pronto=1 at cycle %0d with nothing pending, dout=%h", cyc, dout);
                    hold_val = dout;
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (dout !== e.dout || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL result: dout=%h at cycle %0d, required dout=%h at cycle %0d", dout, cyc, e.dout, e.cyc);
                    end
                    hold_val = e.dout;
                end
            end else begin
                if (rst_at_edge === 1'b1) hold_val = '0;
                checks++;
                if (dout !== hold_val) begin
                    failures++;
                    $display("FAIL dout_hold: dout=%h at cycle %0d, required %h", dout, cyc, hold_val);
                end
            end
        end
    end

    // Reference model of the ALU result.
    function automatic logic [BITS-1:0] modelo(input logic [2:0] o, input logic [BITS-1:0] a,
                                              input logic [BITS-1:0] b);
        logic [2*BITS-1:0] p;
        p = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
        case (o)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return p[BITS-1:0];
            3'd4:    return p[2*BITS-1:BITS];
            3'd5:    return (b == '0) ? '1 : a / b;
            3'd6:    return (b == '0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    // Edges from acceptance to the edge after which pronto is visible.
    function automatic int atraso(input logic [2:0] o, input logic [BITS-1:0] b);
        if (o == 3'd3 || o == 3'd4) return LAT_ITER;
        if ((o == 3'd5 || o == 3'd6) && b != '0) return LAT_ITER;
        return 0;
    endfunction

    // Drive a one-cycle start from a negedge; optionally queue the expected result.
    task automatic issue(input logic [2:0] o, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic [BITS-1:0] im, input logic ui, input bit esperado,
                         output int aceite);
        exp_t            e;
        logic [BITS-1:0] f2;
        op      = o;
        dina    = a;
        dinb    = b;
        imm     = im;
        usa_imm = ui;
        start   = 1'b1;
        aceite  = cyc + 1;
        f2      = ui ? im : b;
        if (esperado) begin
            e.dout = modelo(o, a, f2);
            e.cyc  = aceite + atraso(o, f2);
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) until every queued result has been seen; ends on a negedge.
    task automatic wait_idle(input string nome);
        int n = 0;
        while (sb_q.size() != 0 && n < 4 * BITS) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d results still pending, required 0", nome, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 3'd1; dina = 64'd5; dinb = 64'd6;
        imm = '0; usa_imm = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== '0 || pronto !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: dout=%h pronto=%b ocupado=%b, required 0 0 0", dout, pronto, ocupado);
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pronto !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL start_with_reset: pronto=%b ocupado=%b, required 0 0", pronto, ocupado);
        end
    endtask

    task automatic test_soma_subtrai();
        int k;
        issue(3'd1, 64'd5, 64'd0, -64'sd3, 1'b1, 1'b1, k);
        checks++;
        if (ocupado !== 1'b0 || pronto !== 1'b1) begin
            failures++;
            $display("FAIL soma_imm_timing: ocupado=%b pronto=%b, required 0 1", ocupado, pronto);
        end
        wait_idle("soma_imm");
        issue(3'd1, '1, 64'd2, '0, 1'b0, 1'b1, k);           wait_idle("soma_wrap");
        issue(3'd2, 64'd3, 64'd5, '0, 1'b0, 1'b1, k);         wait_idle("subtrai_borrow");
        issue(3'd0, 64'd9, 64'd9, '0, 1'b0, 1'b1, k);         wait_idle("nao");
        issue(3'd2, 64'd50, 64'd1, 64'd8, 1'b1, 1'b1, k);     wait_idle("subtrai_imm");
        issue(3'd7, 64'd9, 64'd9, '0, 1'b0, 1'b1, k);         wait_idle("reservado");
    endtask

    task automatic test_mul();
        int k;
        issue(3'd3, '1, 64'd2, '0, 1'b0, 1'b1, k);
        checks++;
        if (ocupado !== 1'b1) begin
            failures++;
            $display("FAIL mul_busy: ocupado=%b, required 1", ocupado);
        end
        // Operands change after acceptance; the latched ones must be used.
        dina = 64'h1234; dinb = 64'h0; op = 3'd1;
        while (cyc < k + BITS) @(negedge clk);
        checks++;
        if (ocupado !== 1'b1) begin
            failures++;
            $display("FAIL mul_busy_fim: ocupado=%b at cycle %0d, required 1", ocupado, cyc);
        end
        wait_idle("mul");
        checks++;
        if (ocupado !== 1'b0) begin
            failures++;
            $display("FAIL mul_idle: ocupado=%b, required 0", ocupado);
        end
        issue(3'd4, '1, 64'd2, '0, 1'b0, 1'b1, k);            wait_idle("mulhu");
        issue(3'd4, '1, '1, '0, 1'b0, 1'b1, k);               wait_idle("mulhu_max");
    endtask

    task automatic test_div();
        int k;
        issue(3'd5, 64'd100, 64'd7, '0, 1'b0, 1'b1, k);       wait_idle("divu");
        issue(3'd6, 64'd100, 64'd7, '0, 1'b0, 1'b1, k);       wait_idle("remu");
        issue(3'd5, 64'd100, 64'd0, '0, 1'b0, 1'b1, k);
        checks++;
        if (pronto !== 1'b1 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL divu_zero_timing: pronto=%b ocupado=%b, required 1 0", pronto, ocupado);
        end
        wait_idle("divu_zero");
        issue(3'd6, 64'd100, 64'd0, '0, 1'b0, 1'b1, k);       wait_idle("remu_zero");
        issue(3'd5, '1, 64'd3, '0, 1'b0, 1'b1, k);            wait_idle("divu_big");
        issue(3'd6, 64'd5, 64'd9, 64'd1, 1'b0, 1'b1, k);      wait_idle("remu_small");
    endtask

    task automatic test_back_to_back();
        int k;
        int k2;
        issue(3'd3, 64'd123456789, 64'd987654321, '0, 1'b0, 1'b1, k);
        while (cyc < k + 9) @(negedge clk);
        issue(3'd1, 64'd1, 64'd1, '0, 1'b0, 1'b0, k2);        // ignored while busy
        while (cyc < k + LAT_ITER) @(negedge clk);
        checks++;
        if (pronto !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pronto: pronto=%b at cycle %0d, required 1", pronto, cyc);
        end
        issue(3'd1, 64'd7, 64'd8, '0, 1'b0, 1'b1, k2);
        wait_idle("back_to_back");
    endtask

    task automatic test_reset_abort();
        int k;
        issue(3'd5, 64'd100, 64'd7, '0, 1'b0, 1'b0, k);       // aborted, no result
        while (cyc < k + 29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ocupado !== 1'b0 || dout !== '0 || pronto !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: ocupado=%b dout=%h pronto=%b, required 0 0 0", ocupado, dout, pronto);
        end
        reset = 1'b0;
        issue(3'd6, 64'd100, 64'd7, '0, 1'b0, 1'b1, k);
        wait_idle("after_reset");
    endtask

    task automatic test_flags();
        logic [BITS-1:0] ta[4];
        logic [BITS-1:0] tb[4];
        logic [2:0]      te[4];      // {igual, menor, maior_igual_u}
        int              k;
        ta[0] = '1;     tb[0] = 64'd1;  te[0] = 3'b011;
        ta[1] = 64'd1;  tb[1] = '1;     te[1] = 3'b000;
        ta[2] = 64'd5;  tb[2] = 64'd5;  te[2] = 3'b101;
        ta[3] = 64'd3;  tb[3] = 64'd9;  te[3] = 3'b010;
        for (int i = 0; i < 4; i++) begin
            dina = ta[i]; dinb = tb[i]; usa_imm = i[0]; imm = '1;
            #1;
            checks++;
            if ({flag_igual, flag_menor, flag_maior_igual_u} !== te[i]) begin
                failures++;
                $display("FAIL flags_%0d: flags=%b, required %b", i, {flag_igual, flag_menor, flag_maior_igual_u}, te[i]);
            end
        end
        @(negedge clk);
        issue(3'd3, 64'd6, 64'd7, '0, 1'b0, 1'b1, k);
        dina = '1; dinb = 64'd1; usa_imm = 1'b1; imm = 64'd77;
        @(negedge clk);
        checks++;
        if ({flag_igual, flag_menor, flag_maior_igual_u} !== 3'b011 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL flags_busy: flags=%b ocupado=%b, required 011 1", {flag_igual, flag_menor, flag_maior_igual_u}, ocupado);
        end
        wait_idle("flags_mul");
    endtask

    task automatic test_random();
        int              k;
        logic [2:0]      o;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(0, 7));
            a = {$urandom(), $urandom()};
            case (i % 3)
                0:       b = {$urandom(), $urandom()};
                1:       b = 64'($urandom_range(0, 20));
                default: b = {32'd0, $urandom()};
            endcase
            issue(o, a, b, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b1, k);
            wait_idle("random");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_soma_subtrai();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_abort();
        test_flags();
        test_random();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
